// File: rtl/hamming_seq_ctrl.sv
// Sequencer that streams an N-bit word pair LSB-first into a bit-serial Hamming core
// and presents the captured distance. Optional threshold compare: HAMMING_CTRL_THRESH_EN.
module hamming_seq_ctrl #(
    parameter int N  = 1600,
    parameter int OW = 11,
    parameter int CW = 11
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [N-1:0]  in_x,
    input  logic [N-1:0]  in_y,
`ifdef HAMMING_CTRL_THRESH_EN
    input  logic [OW-1:0] thresh,
    output logic          out_match,
`endif
    output logic          core_x,
    output logic          core_y,
    output logic          core_rst,
    input  logic [OW-1:0] core_o,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [OW-1:0] out_dist,
    output logic          busy
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        CLEAR = 2'd1,
        SHIFT = 2'd2,
        HOLD  = 2'd3
    } state_t;

    state_t        state_r;
    state_t        state_next_s;
    logic [N-1:0]  sx_r;
    logic [N-1:0]  sy_r;
    logic [CW-1:0] cnt_r;
    logic          last_bit_s;
`ifdef HAMMING_CTRL_THRESH_EN
    logic [OW-1:0] thr_r;
`endif

    assign last_bit_s = (cnt_r == CW'(N - 1));
    assign in_ready   = (state_r == IDLE);
    assign busy       = (state_r != IDLE);

    // State register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Next-state decode
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            IDLE: begin
                if (in_valid) state_next_s = CLEAR;
                else          state_next_s = IDLE;
            end
            CLEAR: state_next_s = SHIFT;
            SHIFT: begin
                if (last_bit_s) state_next_s = HOLD;
                else            state_next_s = SHIFT;
            end
            HOLD: begin
                if (out_ready) state_next_s = IDLE;
                else           state_next_s = HOLD;
            end
            default: state_next_s = IDLE;
        endcase
    end

    // Operand shift registers and bit counter; operands load only on an accepted handshake
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sx_r  <= '0;
            sy_r  <= '0;
            cnt_r <= '0;
`ifdef HAMMING_CTRL_THRESH_EN
            thr_r <= '0;
`endif
        end else begin
            case (state_r)
                IDLE: begin
                    if (in_valid) begin
                        sx_r  <= in_x;
                        sy_r  <= in_y;
`ifdef HAMMING_CTRL_THRESH_EN
                        thr_r <= thresh;
`endif
                    end
                end
                CLEAR: begin
                    sx_r  <= sx_r >> 1;
                    sy_r  <= sy_r >> 1;
                    cnt_r <= '0;
                end
                SHIFT: begin
                    sx_r  <= sx_r >> 1;
                    sy_r  <= sy_r >> 1;
                    cnt_r <= cnt_r + CW'(1);
                end
                HOLD: begin
                    cnt_r <= cnt_r;
                end
                default: begin
                    cnt_r <= '0;
                end
            endcase
        end
    end

    // Registered outputs, decoded from the state being entered so they line up with it
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            core_x    <= 1'b0;
            core_y    <= 1'b0;
            core_rst  <= 1'b1;
            out_valid <= 1'b0;
            out_dist  <= '0;
`ifdef HAMMING_CTRL_THRESH_EN
            out_match <= 1'b0;
`endif
        end else begin
            core_rst <= (state_next_s == CLEAR) || (state_next_s == HOLD);
            core_x   <= (state_next_s == SHIFT) ? sx_r[0] : 1'b0;
            core_y   <= (state_next_s == SHIFT) ? sy_r[0] : 1'b0;
            // core_o is combinational, so it already counts the bit on the wire now
            if ((state_r == SHIFT) && last_bit_s) begin
                out_valid <= 1'b1;
                out_dist  <= core_o;
`ifdef HAMMING_CTRL_THRESH_EN
                out_match <= (core_o <= thr_r);
`endif
            end else if ((state_r == HOLD) && out_ready) begin
                out_valid <= 1'b0;
`ifdef HAMMING_CTRL_THRESH_EN
                out_match <= 1'b0;
`endif
            end else begin
                out_valid <= out_valid;
            end
        end
    end

endmodule

// File: tb/tb_hamming_seq_ctrl.sv
// Bench for hamming_seq_ctrl at N=8 with a behavioural serial core and popcount reference.
// Define HAMMING_CTRL_THRESH_EN to also exercise the threshold compare.
module tb_hamming_seq_ctrl;
    localparam int N  = 8;
    localparam int OW = 4;
    localparam int CW = 3;

    logic          clk;
    logic          rst;
    logic          in_valid;
    logic          in_ready;
    logic [N-1:0]  in_x;
    logic [N-1:0]  in_y;
    logic          core_x;
    logic          core_y;
    logic          core_rst;
    logic [OW-1:0] core_o;
    logic          out_valid;
    logic          out_ready;
    logic [OW-1:0] out_dist;
    logic          busy;
`ifdef HAMMING_CTRL_THRESH_EN
    logic [OW-1:0] thresh;
    logic          out_match;
`endif

    int checks;
    int errors;

    hamming_seq_ctrl #(.N(N), .OW(OW), .CW(CW)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_x      (in_x),
        .in_y      (in_y),
`ifdef HAMMING_CTRL_THRESH_EN
        .thresh    (thresh),
        .out_match (out_match),
`endif
        .core_x    (core_x),
        .core_y    (core_y),
        .core_rst  (core_rst),
        .core_o    (core_o),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_dist  (out_dist),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural serial core: registered count, sync clear, combinational running sum
    logic [OW-1:0] core_cnt;
    always @(posedge clk) begin
        if (core_rst) core_cnt <= '0;
        else          core_cnt <= core_cnt + OW'(core_x ^ core_y);
    end
    assign core_o = core_cnt + OW'(core_x ^ core_y);

    task automatic wait_ready(input string tag);
        int n;
        n = 0;
        while (in_ready !== 1'b1 && n < 100) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (in_ready !== 1'b1) begin
            errors++;
            $display("FAIL %s_wait_ready: in_ready=%b required 1 within 100 cycles", tag, in_ready);
        end
    endtask

    // One full transaction with out_ready=1; checks stream, clear pulse, latency and distance
    task automatic run_pair(input logic [N-1:0] x, input logic [N-1:0] y, input string tag);
        logic [N-1:0]  sxs;
        logic [N-1:0]  sys;
        logic [OW-1:0] exp;
        int            bad_rst;
        int            early_valid;
        exp = OW'($countones(x ^ y));
        bad_rst = 0;
        early_valid = 0;
        wait_ready(tag);
        in_x = x;
        in_y = y;
        in_valid = 1'b1;
        out_ready = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        in_x = N'($urandom);
        in_y = N'($urandom);
        checks++;
        if (core_rst !== 1'b1 || core_x !== 1'b0 || busy !== 1'b1) begin
            errors++;
            $display("FAIL %s_clear: core_rst=%b core_x=%b busy=%b required 1 0 1", tag, core_rst, core_x, busy);
        end
        for (int k = 0; k < N; k++) begin
            @(negedge clk);
            sxs[k] = core_x;
            sys[k] = core_y;
            if (core_rst !== 1'b0) bad_rst++;
            if (out_valid !== 1'b0) early_valid++;
        end
        checks++;
        if (sxs !== x || sys !== y) begin
            errors++;
            $display("FAIL %s_stream: x=%h y=%h required %h %h", tag, sxs, sys, x, y);
        end
        checks++;
        if (bad_rst != 0 || early_valid != 0) begin
            errors++;
            $display("FAIL %s_shift: core_rst high %0d, out_valid early %0d, required 0 0", tag, bad_rst, early_valid);
        end
        @(negedge clk);
        checks++;
        if (out_valid !== 1'b1 || out_dist !== exp) begin
            errors++;
            $display("FAIL %s_result: out_valid=%b out_dist=%0d required 1 %0d", tag, out_valid, out_dist, exp);
        end
`ifdef HAMMING_CTRL_THRESH_EN
        checks++;
        if (out_match !== (exp <= thresh)) begin
            errors++;
            $display("FAIL %s_match: out_match=%b required %b", tag, out_match, (exp <= thresh));
        end
`endif
        @(negedge clk);
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            errors++;
            $display("FAIL %s_release: out_valid=%b in_ready=%b required 0 1", tag, out_valid, in_ready);
        end
    endtask

    task automatic test_reset();
        rst = 1'b0;
        in_valid = 1'b0;
        out_ready = 1'b0;
        in_x = '0;
        in_y = '0;
`ifdef HAMMING_CTRL_THRESH_EN
        thresh = '0;
`endif
        repeat (2) @(negedge clk);
        checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0 || out_dist !== '0 || core_rst !== 1'b1
            || core_x !== 1'b0 || core_y !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL reset_values: rdy=%b vld=%b dist=%0d crst=%b cx=%b cy=%b busy=%b required 1 0 0 1 0 0 0",
                     in_ready, out_valid, out_dist, core_rst, core_x, core_y, busy);
        end
        rst = 1'b1;
        @(negedge clk);
        checks++;
        if (core_rst !== 1'b0 || in_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_idle: core_rst=%b in_ready=%b required 0 1", core_rst, in_ready);
        end
    endtask

    task automatic test_directed();
        run_pair(8'hA5, 8'h5A, "a5_5a");
        run_pair(8'h3C, 8'h3C, "equal");
        run_pair(8'h00, 8'h01, "lsb_only");
        run_pair(8'h00, 8'h80, "msb_only");
        for (int i = 0; i < 4; i++) run_pair(N'($urandom), N'($urandom), "random");
    endtask

    task automatic test_backpressure();
        logic [N-1:0]  ax, ay, bx, by;
        logic [OW-1:0] expa, expb;
        int            n;
        int            bad;
        ax = N'($urandom); ay = N'($urandom);
        bx = N'($urandom); by = N'($urandom);
        expa = OW'($countones(ax ^ ay));
        expb = OW'($countones(bx ^ by));
        wait_ready("bp");
        in_x = ax; in_y = ay; in_valid = 1'b1; out_ready = 1'b0;
        @(negedge clk);
        in_x = bx; in_y = by;
        n = 0;
        bad = 0;
        while (out_valid !== 1'b1 && n < 50) begin
            if (in_ready !== 1'b0) bad++;
            @(negedge clk);
            n++;
        end
        for (int i = 0; i < 20; i++) begin
            if (out_valid !== 1'b1 || out_dist !== expa || in_ready !== 1'b0) bad++;
            @(negedge clk);
        end
        checks++;
        if (bad != 0 || out_dist !== expa) begin
            errors++;
            $display("FAIL bp_hold: violations=%0d out_dist=%0d required 0 %0d", bad, out_dist, expa);
        end
        out_ready = 1'b1;
        @(negedge clk);
        checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            errors++;
            $display("FAIL bp_release: in_ready=%b out_valid=%b required 1 0", in_ready, out_valid);
        end
        @(negedge clk);
        in_valid = 1'b0;
        checks++;
        if (in_ready !== 1'b0 || core_rst !== 1'b1) begin
            errors++;
            $display("FAIL bp_second_accept: in_ready=%b core_rst=%b required 0 1", in_ready, core_rst);
        end
        n = 0;
        while (out_valid !== 1'b1 && n < 50) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (out_valid !== 1'b1 || out_dist !== expb) begin
            errors++;
            $display("FAIL bp_second_result: out_valid=%b out_dist=%0d required 1 %0d", out_valid, out_dist, expb);
        end
        @(negedge clk);
    endtask

    task automatic test_reset_mid_shift();
        wait_ready("mid_rst");
        in_x = 8'hFF; in_y = 8'h00; in_valid = 1'b1; out_ready = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        repeat (4) @(negedge clk);
        #1 rst = 1'b0;
        #1;
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1 || core_rst !== 1'b1 || busy !== 1'b0) begin
            errors++;
            $display("FAIL mid_reset: vld=%b rdy=%b crst=%b busy=%b required 0 1 1 0", out_valid, in_ready, core_rst, busy);
        end
        repeat (2) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        run_pair(8'h0F, 8'h01, "after_reset");
    endtask

    task automatic test_back_to_back();
        logic [OW-1:0] expq[$];
        logic [N-1:0]  x, y;
        logic [OW-1:0] e;
        int            issued, popped, last_rdy, gap_bad, res_bad;
        issued = 0; popped = 0; last_rdy = -1; gap_bad = 0; res_bad = 0;
        out_ready = 1'b1;
        for (int cyc = 0; cyc < 2000 && popped < 50; cyc++) begin
            if (out_valid === 1'b1) begin
                e = (expq.size() > 0) ? expq.pop_front() : '0;
                if (out_dist !== e) begin
                    res_bad++;
                    if (res_bad <= 3) $display("FAIL b2b_result %0d: out_dist=%0d required %0d", popped, out_dist, e);
                end
                popped++;
            end
            if (popped < 50 && in_ready === 1'b1) begin
                if (last_rdy >= 0 && cyc - last_rdy != N + 3) gap_bad++;
                last_rdy = cyc;
                if (issued < 50) begin
                    x = N'($urandom); y = N'($urandom);
                    in_x = x; in_y = y; in_valid = 1'b1;
                    expq.push_back(OW'($countones(x ^ y)));
                    issued++;
                end else begin
                    in_valid = 1'b0;
                end
            end
            @(negedge clk);
        end
        in_valid = 1'b0;
        checks++;
        if (popped != 50 || res_bad != 0) begin
            errors++;
            $display("FAIL b2b_results: got %0d results with %0d wrong, required 50 with 0 wrong", popped, res_bad);
        end
        checks++;
        if (gap_bad != 0) begin
            errors++;
            $display("FAIL b2b_spacing: %0d in_ready gaps differ from %0d cycles, required 0", gap_bad, N + 3);
        end
        repeat (2) @(negedge clk);
    endtask

`ifdef HAMMING_CTRL_THRESH_EN
    task automatic test_thresh();
        thresh = 4'd4;
        run_pair(8'h0F, 8'h00, "thr_eq");
        run_pair(8'h1F, 8'h00, "thr_above");
        thresh = 4'd0;
        run_pair(8'h6B, 8'h6B, "thr_zero");
    endtask
`endif

    initial begin
        checks = 0;
        errors = 0;
        test_reset();
        test_directed();
        test_backpressure();
        test_reset_mid_shift();
        test_back_to_back();
`ifdef HAMMING_CTRL_THRESH_EN
        test_thresh();
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
